// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage of the 5-stage pipeline. Owns the
//               program counter, presents it as the byte address to a
//               combinational instruction memory, and latches the returned
//               word into the IF/ID pipeline register. Supports stall, flush
//               and branch/jump redirect, and counts valid fetches.
// Ports       :
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous active-high reset
//   stall          in   1   hold PC and IF/ID
//   flush          in   1   squash IF/ID to a bubble
//   branch_taken   in   1   redirect PC to branch_target
//   branch_target  in   32  redirect byte address (bits [1:0] ignored)
//   imem_addr      out  32  byte address to instruction memory (= pc)
//   imem_instr     in   32  instruction word for imem_addr, same cycle
//   pc             out  32  current fetch PC
//   if_id_pc       out  32  PC of instruction held in IF/ID
//   if_id_pc4      out  32  if_id_pc + 4
//   if_id_instr    out  32  instruction held in IF/ID
//   if_id_valid    out  1   IF/ID holds a real instruction (0 = bubble)
//   fetch_count    out  32  instructions latched valid into IF/ID
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] pc,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic [31:0] fetch_count
);

   logic [31:0] r_pc;
   logic [31:0] r_if_id_pc;
   logic [31:0] r_if_id_pc4;
   logic [31:0] r_if_id_instr;
   logic        r_if_id_valid;
   logic [31:0] r_fetch_count;

   logic [31:0] w_pc4;
   logic [31:0] w_target;
   logic        w_bubble;
   logic        w_load;
   logic        w_unused_tgt;

   // Natural 32-bit wrap gives 0xFFFF_FFFC -> 0x0000_0000.
   assign w_pc4        = r_pc + 32'd4;
   assign w_target     = {branch_target[31:2], 2'b00};
   assign w_unused_tgt = ^branch_target[1:0];

   // A redirect squashes the wrong-path word in IF/ID just like a flush,
   // and both take precedence over a stall.
   assign w_bubble = branch_taken | flush;
   assign w_load   = ~w_bubble & ~stall;

   // Program counter: rst > branch_taken > stall > increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else if (branch_taken) begin
         r_pc <= w_target;
      end else if (!stall) begin
         r_pc <= w_pc4;
      end
   end

   // IF/ID register: rst > bubble > stall > load.
   always_ff @(posedge clk) begin
      if (rst || w_bubble) begin
         r_if_id_pc    <= 32'd0;
         r_if_id_pc4   <= 32'd0;
         r_if_id_instr <= NOP_INSTR;
         r_if_id_valid <= 1'b0;
      end else if (w_load) begin
         r_if_id_pc    <= r_pc;
         r_if_id_pc4   <= w_pc4;
         r_if_id_instr <= imem_instr;
         r_if_id_valid <= 1'b1;
      end
   end

   // Counts only cycles that latch a real instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_count <= 32'd0;
      end else if (w_load) begin
         r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign if_id_pc    = r_if_id_pc;
   assign if_id_pc4   = r_if_id_pc4;
   assign if_id_instr = r_if_id_instr;
   assign if_id_valid = r_if_id_valid;
   assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage. Two instances share the
//               control inputs: one with the default reset PC and one with a
//               reset PC of 0xFFFF_FFFC. A behavioural model predicts every
//               output each cycle, plus directed scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;

   logic [31:0] mem [0:255];

   logic [31:0] addr0, instr0, pc0, ipc0, ipc40, iins0, cnt0;
   logic        ival0;
   logic [31:0] addr1, instr1, pc1, ipc1, ipc41, iins1, cnt1;
   logic        ival1;

   int n_cmp;
   int n_err;

   // Behavioural reference state, index 0/1 per instance.
   logic [31:0] m_pc   [2];
   logic [31:0] m_ipc  [2];
   logic [31:0] m_ipc4 [2];
   logic [31:0] m_ins  [2];
   logic        m_val  [2];
   logic [31:0] m_cnt  [2];
   logic [31:0] m_rst_pc [2];

   assign instr0 = mem[addr0[9:2]];
   assign instr1 = mem[addr1[9:2]];

   if_stage u_dut0 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(addr0), .imem_instr(instr0), .pc(pc0),
      .if_id_pc(ipc0), .if_id_pc4(ipc40), .if_id_instr(iins0),
      .if_id_valid(ival0), .fetch_count(cnt0)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(addr1), .imem_instr(instr1), .pc(pc1),
      .if_id_pc(ipc1), .if_id_pc4(ipc41), .if_id_instr(iins1),
      .if_id_valid(ival1), .fetch_count(cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock of the architectural rules, evaluated on pre-edge values.
   task automatic model_step();
      logic [31:0] fetched;
      logic [31:0] cur;
      for (int k = 0; k < 2; k++) begin
         cur     = m_pc[k];
         fetched = mem[cur[9:2]];
         if (rst) begin
            m_pc[k]   = m_rst_pc[k];
            m_ipc[k]  = 0; m_ipc4[k] = 0; m_ins[k] = 0; m_val[k] = 0;
            m_cnt[k]  = 0;
         end else begin
            if (branch_taken)  m_pc[k] = branch_target & 32'hFFFF_FFFC;
            else if (!stall)   m_pc[k] = cur + 4;
            if (branch_taken || flush) begin
               m_ipc[k] = 0; m_ipc4[k] = 0; m_ins[k] = 0; m_val[k] = 0;
            end else if (!stall) begin
               m_ipc[k]  = cur;
               m_ipc4[k] = cur + 4;
               m_ins[k]  = fetched;
               m_val[k]  = 1;
               m_cnt[k]  = m_cnt[k] + 1;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("pc0",     pc0,   m_pc[0]);
      check("addr0",   addr0, m_pc[0]);
      check("ifpc0",   ipc0,  m_ipc[0]);
      check("ifpc4_0", ipc40, m_ipc4[0]);
      check("ifins0",  iins0, m_ins[0]);
      check("ifval0",  {31'd0, ival0}, {31'd0, m_val[0]});
      check("cnt0",    cnt0,  m_cnt[0]);
      check("pc1",     pc1,   m_pc[1]);
      check("addr1",   addr1, m_pc[1]);
      check("ifpc1",   ipc1,  m_ipc[1]);
      check("ifpc4_1", ipc41, m_ipc4[1]);
      check("ifins1",  iins1, m_ins[1]);
      check("ifval1",  {31'd0, ival1}, {31'd0, m_val[1]});
      check("cnt1",    cnt1,  m_cnt[1]);
   endtask

   // Drive inputs at negedge, advance model at posedge, check #1 later.
   task automatic cycle(input logic r, input logic s, input logic f,
                        input logic b, input logic [31:0] t);
      @(negedge clk);
      rst = r; stall = s; flush = f; branch_taken = b; branch_target = t;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
      branch_target = 32'd0;
      m_rst_pc[0] = 32'h0000_0000;
      m_rst_pc[1] = 32'hFFFF_FFFC;
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = 0; m_ipc[k] = 0; m_ipc4[k] = 0; m_ins[k] = 0;
         m_val[k] = 0; m_cnt[k] = 0;
      end
      for (int i = 0; i < 256; i++) begin
         mem[i] = (i < 4) ? (32'hA000_0000 | i) : $urandom;
      end

      // Reset for two cycles.
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      check("rst_pc",    pc0,  32'h0);
      check("rst_valid", {31'd0, ival0}, 32'h0);
      check("rst_instr", iins0, 32'h0);
      check("rst_cnt",   cnt0,  32'h0);
      check("rst_pc1",   pc1,   32'hFFFF_FFFC);

      // Sequential fetch A0..A3; second instance wraps on the first cycle.
      cycle(0, 0, 0, 0, 0);
      check("seq_ins0", iins0, 32'hA000_0000);
      check("seq_pc0",  ipc0,  32'h0);
      check("wrap_pc1", pc1,   32'h0);
      check("wrap_ipc", ipc1,  32'hFFFF_FFFC);
      check("wrap_pc4", ipc41, 32'h0);
      cycle(0, 0, 0, 0, 0);
      check("seq_ins1", iins0, 32'hA000_0001);
      check("seq_pc1",  ipc0,  32'h4);
      cycle(0, 0, 0, 0, 0);
      check("seq_ins2", iins0, 32'hA000_0002);
      check("seq_pc2",  ipc0,  32'h8);
      cycle(0, 0, 0, 0, 0);
      check("seq_ins3", iins0, 32'hA000_0003);
      check("seq_pc3",  ipc0,  32'hC);
      check("seq_pc",   pc0,   32'h10);
      check("seq_cnt",  cnt0,  32'd4);

      // Stall at pc=8 for three cycles, then release.
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
      check("stl_pc",   pc0,   32'h8);
      check("stl_ipc",  ipc0,  32'h4);
      check("stl_ins",  iins0, 32'hA000_0001);
      check("stl_cnt",  cnt0,  32'd2);
      cycle(0, 0, 0, 0, 0);
      check("rel_ins",  iins0, 32'hA000_0002);
      check("rel_ipc",  ipc0,  32'h8);

      // Redirect at pc=0xC to 0x41 (low bits dropped).
      cycle(0, 0, 0, 1, 32'h41);
      check("br_pc",    pc0,   32'h40);
      check("br_val",   {31'd0, ival0}, 32'h0);
      cycle(0, 0, 0, 0, 0);
      check("br_ins",   iins0, mem[16]);
      check("br_ipc",   ipc0,  32'h40);

      // Redirect beats stall; flush with stall bubbles but holds PC.
      cycle(0, 1, 0, 1, 32'h20);
      check("brst_pc",  pc0,   32'h20);
      check("brst_val", {31'd0, ival0}, 32'h0);
      cycle(0, 1, 1, 0, 0);
      check("flst_pc",  pc0,   32'h20);
      check("flst_val", {31'd0, ival0}, 32'h0);

      // Reset asserted in the middle of a stall.
      cycle(0, 1, 0, 0, 0);
      cycle(1, 1, 0, 0, 0);
      check("rstst_pc",  pc0, 32'h0);
      check("rstst_pc1", pc1, 32'hFFFF_FFFC);
      check("rstst_cnt", cnt0, 32'h0);
      check("rstst_val", {31'd0, ival1}, 32'h0);

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
         cycle(($urandom_range(0, 99) < 2),
               ($urandom_range(0, 99) < 20),
               ($urandom_range(0, 99) < 10),
               ($urandom_range(0, 99) < 10),
               tgt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
